// File: rtl/banco_registro_pkg.sv
// Shared widths and types for the 16-bit datapath register file.
package banco_registro_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int NREG   = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/banco_registro_if.sv
// Decode-side bus of the register file: write/read-A select, read-B select, data.
interface banco_registro_if;
  import banco_registro_pkg::*;

  // No handshake: a write happens on every rising clock where Hab_Escrita=1;
  // A and B are combinational views of the selected registers, valid every cycle.
  logic      Hab_Escrita;
  reg_addr_t Sel_E_SA;
  reg_addr_t Sel_SB;
  word_t     E;
  word_t     A;
  word_t     B;

  modport master (
    output Hab_Escrita, Sel_E_SA, Sel_SB, E,
    input  A, B
  );

  modport slave (
    input  Hab_Escrita, Sel_E_SA, Sel_SB, E,
    output A, B
  );
endinterface

// File: rtl/banco_registro_cell.sv
// One DATA_W-bit storage register with asynchronous clear and write enable.
module banco_registro_cell
  import banco_registro_pkg::*;
(
  input  logic  clock,
  input  logic  reset,
  input  logic  we,
  input  word_t d,
  output word_t q
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/banco_registro.sv
// Eight-entry register file, shared write/read-A port plus independent read-B port.
// Build option: BANCO_REGISTRO_R0_ZERO_EN hardwires register 0 to zero.
module banco_registro
  import banco_registro_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  banco_registro_if.slave   bus
);

  word_t regs [NREG];

  for (genvar i = 0; i < NREG; i++) begin : g_reg
`ifdef BANCO_REGISTRO_R0_ZERO_EN
    if (i == 0) begin : g_zero
      assign regs[i] = '0;
    end else begin : g_cell
      // Enable is gated by Hab_Escrita first so unknown selects cannot write.
      logic we;
      assign we = bus.Hab_Escrita && (bus.Sel_E_SA == reg_addr_t'(i));
      banco_registro_cell u_cell (
        .clock (clock),
        .reset (reset),
        .we    (we),
        .d     (bus.E),
        .q     (regs[i])
      );
    end
`else
    logic we;
    assign we = bus.Hab_Escrita && (bus.Sel_E_SA == reg_addr_t'(i));
    banco_registro_cell u_cell (
      .clock (clock),
      .reset (reset),
      .we    (we),
      .d     (bus.E),
      .q     (regs[i])
    );
`endif
  end

  // No write bypass: reads show stored contents until the edge commits E.
  assign bus.A = regs[bus.Sel_E_SA];
  assign bus.B = regs[bus.Sel_SB];

endmodule

// File: tb/tb_banco_registro.sv
// Directed plus random checks of banco_registro against an array-based model.
module tb_banco_registro;
  import banco_registro_pkg::*;

`ifdef BANCO_REGISTRO_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  logic clock;
  logic reset;
  banco_registro_if bus ();

  banco_registro dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // clock/reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // reference model: plain array of register contents
  word_t model [NREG];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input word_t obs, input word_t exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NREG; i++) model[i] = '0;
  endtask

  function automatic word_t model_read(input int addr);
    return (R0_ZERO && addr == 0) ? word_t'(0) : model[addr];
  endfunction

  // driver: one write edge, inputs changed on the falling edge
  task automatic drive_write(input int addr, input word_t data);
    @(negedge clock);
    bus.Hab_Escrita = 1'b1;
    bus.Sel_E_SA    = reg_addr_t'(addr);
    bus.E           = data;
    @(posedge clock);
    #1;
    bus.Hab_Escrita = 1'b0;
    if (!(R0_ZERO && addr == 0)) model[addr] = data;
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < NREG; i++) begin
      bus.Sel_E_SA = reg_addr_t'(i);
      bus.Sel_SB   = reg_addr_t'(NREG - 1 - i);
      #1;
      check(tag, bus.A, model_read(i));
      check(tag, bus.B, model_read(NREG - 1 - i));
    end
  endtask

  initial begin
    int a, b;
    bit we;
    word_t d;

    reset           = 1'b1;
    bus.Hab_Escrita = 1'b0;
    bus.Sel_E_SA    = '0;
    bus.Sel_SB      = '0;
    bus.E           = '0;
    model_clear();
    #1;
    check_all("reset_initial");
    @(negedge clock);
    reset = 1'b0;

    // reset clears immediately, without a clock edge
    drive_write(3, 16'h1234);
    bus.Sel_E_SA = 3'd3;
    bus.Sel_SB   = 3'd3;
    #1;
    check("preload_r3_a", bus.A, 16'h1234);
    check("preload_r3_b", bus.B, 16'h1234);
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    model_clear();
    check("async_reset_a", bus.A, 16'h0000);
    check("async_reset_b", bus.B, 16'h0000);
    // a write edge during reset is discarded
    bus.Hab_Escrita = 1'b1;
    bus.E           = 16'h5555;
    @(posedge clock);
    #1;
    check("reset_dominates_write", bus.A, 16'h0000);
    @(negedge clock);
    bus.Hab_Escrita = 1'b0;
    reset = 1'b0;
    check_all("after_reset_release");

    // basic write then read on both ports
    drive_write(5, 16'hA5A5);
    bus.Sel_E_SA = 3'd5;
    #1;
    check("write5_a", bus.A, 16'hA5A5);
    bus.Sel_SB = 3'd5;
    #1;
    check("write5_b", bus.B, 16'hA5A5);
    check_all("write5_others");

    // write disabled across three edges
    @(negedge clock);
    bus.Hab_Escrita = 1'b0;
    bus.Sel_E_SA    = 3'd2;
    bus.E           = 16'hFFFF;
    repeat (3) @(posedge clock);
    #1;
    check("write_disabled_r2", bus.A, 16'h0000);

    // read during write, both ports on the written address
    drive_write(1, 16'h0010);
    @(negedge clock);
    bus.Sel_E_SA    = 3'd1;
    bus.Sel_SB      = 3'd1;
    bus.E           = 16'h0020;
    bus.Hab_Escrita = 1'b1;
    #1;
    check("rdw_before_a", bus.A, 16'h0010);
    check("rdw_before_b", bus.B, 16'h0010);
    @(posedge clock);
    #1;
    bus.Hab_Escrita = 1'b0;
    model[1] = 16'h0020;
    check("rdw_after_a", bus.A, 16'h0020);
    check("rdw_after_b", bus.B, 16'h0020);

    // R0 behaviour
    drive_write(0, 16'hBEEF);
    bus.Sel_E_SA = 3'd0;
    #1;
    check("r0_write", bus.A, R0_ZERO ? 16'h0000 : 16'hBEEF);

    // dual independent reads across a loaded file
    for (int i = 0; i < NREG; i++) drive_write(i, word_t'(16'h1000 + i));
    for (int i = 0; i < NREG; i++) begin
      bus.Sel_E_SA = reg_addr_t'(i);
      bus.Sel_SB   = reg_addr_t'(7 - i);
      #1;
      check("sweep_a", bus.A, (R0_ZERO && i == 0) ? 16'h0000 : word_t'(16'h1000 + i));
      check("sweep_b", bus.B, (R0_ZERO && i == 7) ? 16'h0000 : word_t'(16'h1007 - i));
    end

    // unknown selects with writes disabled leave storage intact
    @(negedge clock);
    bus.Hab_Escrita = 1'b0;
    bus.Sel_E_SA    = 'x;
    bus.Sel_SB      = 'x;
    bus.E           = 16'hDEAD;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_all("x_select_no_write");

    // randomized traffic, including back-to-back writes to one register
    for (int n = 0; n < 200; n++) begin
      @(negedge clock);
      we = 1'($urandom_range(0, 1));
      a  = $urandom_range(0, NREG - 1);
      b  = (n % 5 == 0) ? a : $urandom_range(0, NREG - 1);
      d  = word_t'($urandom);
      bus.Hab_Escrita = we;
      bus.Sel_E_SA    = reg_addr_t'(a);
      bus.Sel_SB      = reg_addr_t'(b);
      bus.E           = d;
      #1;
      check("rand_pre_a", bus.A, model_read(a));
      check("rand_pre_b", bus.B, model_read(b));
      @(posedge clock);
      #1;
      if (we && !(R0_ZERO && a == 0)) model[a] = d;
      check("rand_post_a", bus.A, model_read(a));
      check("rand_post_b", bus.B, model_read(b));
    end
    bus.Hab_Escrita = 1'b0;
    check_all("final_contents");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
